// File: rtl/video_to_axis_pkg.sv
// Shared definitions for the video capture bridge: sync FSM states and the G/B byte swap
// that undoes the display-path swap.
package video_to_axis_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    function automatic logic [23:0] swap_gb(input logic [23:0] d);
        return {d[23:16], d[7:0], d[15:8]};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; dout shows the head word whenever empty=0.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    // Full is judged on the pre-pop count, so a same-cycle pop never admits the write.
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/video_to_axis.sv
// Pixel-timing to AXI4-Stream bridge: TUSER on the first pixel after vsync, TLAST at the end
// of each active line; on FIFO overflow the rest of the frame is dropped until the next vsync.
module video_to_axis
    import video_to_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter bit          SWAP_GB    = 1'b1
) (
    input  logic                  video_clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] vid_data,
    input  logic                  vid_hsync,
    input  logic                  vid_vsync,
    input  logic                  vid_active_video,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  locked,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    logic [DATA_WIDTH-1:0] data_d1;
    logic                  active_d1;
    logic                  vsync_d1;
    logic                  vsync_rise;
    logic                  line_end;
    logic [DATA_WIDTH-1:0] pix;
    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  sof_pending_q;
    logic                  in_run;
    logic                  wr_en;
    logic                  drop;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH+1:0] dout;
    logic                  unused_hsync;

    assign unused_hsync = vid_hsync;

    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            data_d1   <= '0;
            active_d1 <= 1'b0;
            vsync_d1  <= 1'b0;
        end else begin
            data_d1   <= vid_data;
            active_d1 <= vid_active_video;
            vsync_d1  <= vid_vsync;
        end
    end

    assign vsync_rise = vid_vsync & ~vsync_d1;
    // Looking one cycle ahead at the live qualifier tells us the pixel in d1 ends its line.
    assign line_end   = active_d1 & ~vid_active_video;

    always_comb begin
        pix = data_d1;
        if (SWAP_GB) pix[23:0] = swap_gb(data_d1[23:0]);
    end

    assign in_run = (state_q == RUN);
    assign wr_en  = in_run & active_d1 & ~full;
    assign drop   = in_run & active_d1 & full;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vsync_rise) state_d = RUN;
            RUN:     if (drop) state_d = DROP;
            DROP:    if (vsync_rise) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sof_pending_q <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (vsync_rise)  sof_pending_q <= 1'b1;
            else if (wr_en)  sof_pending_q <= 1'b0;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (video_clk),
        .rst   (reset),
        .wr_en (wr_en),
        .din   ({sof_pending_q, line_end, pix}),
        .full  (full),
        .rd_en (m_axis_tready),
        .dout  (dout),
        .empty (empty)
    );

    assign locked        = in_run;
    assign m_axis_tvalid = ~empty;
    assign m_axis_tuser  = empty ? 1'b0 : dout[DATA_WIDTH+1];
    assign m_axis_tlast  = empty ? 1'b0 : dout[DATA_WIDTH];
    assign m_axis_tdata  = empty ? '0 : dout[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_video_to_axis.sv
// Bench for video_to_axis: randomized pixel frames checked against a frame-level model of
// the expected AXI4-Stream beats.
module tb_video_to_axis;

    localparam int DW    = 24;
    localparam int DEPTH = 32;

    logic          video_clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] vid_data = '0;
    logic          vid_hsync = 1'b0;
    logic          vid_vsync = 1'b0;
    logic          vid_active_video = 1'b0;
    logic          m_axis_tready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          locked;
    logic          overflow;
    logic [DW-1:0] ns_tdata;
    logic          ns_tvalid;
    logic          ns_unused_tuser;
    logic          ns_unused_tlast;
    logic          ns_unused_locked;
    logic          ns_unused_overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] beat_q[$];
    int            beat_cyc[$];

    always #5 video_clk = ~video_clk;

    video_to_axis #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SWAP_GB(1'b1)) dut (
        .video_clk        (video_clk),
        .reset            (reset),
        .vid_data         (vid_data),
        .vid_hsync        (vid_hsync),
        .vid_vsync        (vid_vsync),
        .vid_active_video (vid_active_video),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tlast     (m_axis_tlast),
        .locked           (locked),
        .overflow         (overflow),
        .clr_overflow     (clr_overflow)
    );

    video_to_axis #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SWAP_GB(1'b0)) dut_ns (
        .video_clk        (video_clk),
        .reset            (reset),
        .vid_data         (vid_data),
        .vid_hsync        (vid_hsync),
        .vid_vsync        (vid_vsync),
        .vid_active_video (vid_active_video),
        .m_axis_tdata     (ns_tdata),
        .m_axis_tvalid    (ns_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tuser     (ns_unused_tuser),
        .m_axis_tlast     (ns_unused_tlast),
        .locked           (ns_unused_locked),
        .overflow         (ns_unused_overflow),
        .clr_overflow     (clr_overflow)
    );

    always @(posedge video_clk) cyc <= cyc + 1;

    always @(negedge video_clk) begin
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            beat_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            beat_cyc.push_back(cyc);
        end
    end

    function automatic logic [DW-1:0] ref_map(input logic [DW-1:0] d);
        return {d[23:16], d[7:0], d[15:8]};
    endfunction

    task automatic tick();
        @(posedge video_clk);
        #1;
        if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic vsync_pulse();
        vid_vsync = 1'b1;
        repeat (3) tick();
        vid_vsync = 1'b0;
        repeat (4) tick();
    endtask

    // Model: every pixel of a locked frame becomes one beat; the first after vsync has tuser.
    task automatic send_lines(input int lines, input int px, input int blank, input bit record,
                              input bit sof, output int first_cyc);
        bit first = sof;
        first_cyc = -1;
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < px; p++) begin
                vid_active_video = 1'b1;
                vid_hsync = 1'b0;
                vid_data = DW'($urandom);
                if (first_cyc < 0) first_cyc = cyc;
                if (record) exp_q.push_back({first, p == px - 1, ref_map(vid_data)});
                first = 1'b0;
                tick();
            end
            vid_active_video = 1'b0;
            vid_hsync = 1'b1;
            for (int b = 0; b < blank; b++) begin
                vid_data = DW'($urandom);
                tick();
            end
            vid_hsync = 1'b0;
        end
    endtask

    task automatic send_frame(input int lines, input int px, input int blank,
                              output int first_cyc);
        vsync_pulse();
        send_lines(lines, px, blank, 1'b1, 1'b1, first_cyc);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beat_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks += 6;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser: got %b want 0", m_axis_tuser); end
        if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_timing();
        int first;
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        exp_q.delete(); beat_q.delete(); beat_cyc.delete();
        send_frame(4, 8, 8, first);
        wait_beats(32, 100);
        checks += 2;
        if (beat_q.size() != 32) begin errors++; $display("FAIL timing_count: got %0d want 32", beat_q.size()); end
        if (beat_cyc.size() == 0 || beat_cyc[0] != first + 2) begin
            errors++;
            $display("FAIL timing_latency: got %0d want %0d", beat_cyc.size() ? beat_cyc[0] : -1, first + 2);
        end
        for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (beat_q[i] !== exp_q[i]) begin errors++; $display("FAIL timing_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL timing_locked: got %b want 1", locked); end
    endtask

    task automatic test_reset_midframe();
        int first;
        rand_ready = 1'b1;
        send_lines(1, 8, 4, 1'b0, 1'b0, first);
        vid_active_video = 1'b1;
        repeat (3) begin vid_data = DW'($urandom); tick(); end
        reset = 1'b1;
        repeat (2) begin vid_data = DW'($urandom); tick(); end
        reset = 1'b0;
        beat_q.delete(); beat_cyc.delete();
        repeat (5) begin vid_data = DW'($urandom); tick(); end
        vid_active_video = 1'b0;
        repeat (8) tick();
        send_lines(2, 8, 8, 1'b0, 1'b0, first);
        repeat (20) tick();
        checks += 2;
        if (beat_q.size() != 0) begin errors++; $display("FAIL midreset_nobeats: got %0d want 0", beat_q.size()); end
        if (locked !== 1'b0) begin errors++; $display("FAIL midreset_unlocked: got %b want 0", locked); end
        exp_q.delete();
        send_frame(2, 8, 16, first);
        wait_beats(16, 200);
        checks += 2;
        if (beat_q.size() != 16) begin errors++; $display("FAIL midreset_count: got %0d want 16", beat_q.size()); end
        if (locked !== 1'b1) begin errors++; $display("FAIL midreset_locked: got %b want 1", locked); end
        for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (beat_q[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        int first;
        rand_ready = 1'b0;
        m_axis_tready = 1'b0;
        exp_q.delete(); beat_q.delete(); beat_cyc.delete();
        send_frame(1, 64, 8, first);
        // Only what fits in the FIFO before the first drop survives.
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        checks += 3;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        if (locked !== 1'b0) begin errors++; $display("FAIL ovf_unlocked: got %b want 0", locked); end
        if (beat_q.size() != 0) begin errors++; $display("FAIL ovf_stalled: got %0d want 0", beat_q.size()); end
        m_axis_tready = 1'b1;
        repeat (40) tick();
        checks++;
        if (beat_q.size() != DEPTH) begin errors++; $display("FAIL ovf_drain_count: got %0d want %0d", beat_q.size(), DEPTH); end
        for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (beat_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
        end
        send_lines(2, 8, 8, 1'b0, 1'b0, first);
        repeat (4) tick();
        checks++;
        if (beat_q.size() != DEPTH) begin errors++; $display("FAIL ovf_dropped: got %0d want %0d", beat_q.size(), DEPTH); end
        exp_q.delete(); beat_q.delete(); beat_cyc.delete();
        rand_ready = 1'b1;
        send_frame(2, 8, 16, first);
        wait_beats(16, 200);
        checks += 2;
        if (beat_q.size() != 16) begin errors++; $display("FAIL ovf_recover_count: got %0d want 16", beat_q.size()); end
        if (locked !== 1'b1) begin errors++; $display("FAIL ovf_relocked: got %b want 1", locked); end
        for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (beat_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_recover_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_swap();
        rand_ready = 1'b0;
        m_axis_tready = 1'b0;
        vsync_pulse();
        vid_data = 24'h112233;
        vid_active_video = 1'b1;
        tick();
        vid_active_video = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL swap_tvalid: got %b want 1", m_axis_tvalid); end
        if (m_axis_tdata !== 24'h113322) begin errors++; $display("FAIL swap_on_tdata: got %h want 113322", m_axis_tdata); end
        if (m_axis_tuser !== 1'b1) begin errors++; $display("FAIL swap_tuser: got %b want 1", m_axis_tuser); end
        if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL swap_tlast: got %b want 1", m_axis_tlast); end
        if (ns_tvalid !== 1'b1) begin errors++; $display("FAIL swap_off_tvalid: got %b want 1", ns_tvalid); end
        if (ns_tdata !== 24'h112233) begin errors++; $display("FAIL swap_off_tdata: got %h want 112233", ns_tdata); end
        m_axis_tready = 1'b1;
        repeat (3) tick();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL swap_drained: got %b want 0", m_axis_tvalid); end
        beat_q.delete(); beat_cyc.delete();
    endtask

    task automatic test_reset_full();
        int first;
        m_axis_tready = 1'b0;
        vsync_pulse();
        send_lines(1, 10, 4, 1'b0, 1'b0, first);
        checks++;
        if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rstfull_prefill: got %b want 1", m_axis_tvalid); end
        reset = 1'b1;
        #1;
        checks += 2;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstfull_tvalid: got %b want 0", m_axis_tvalid); end
        if (locked !== 1'b0) begin errors++; $display("FAIL rstfull_locked: got %b want 0", locked); end
        tick();
        reset = 1'b0;
        tick();
        beat_q.delete(); beat_cyc.delete();
        m_axis_tready = 1'b1;
        send_lines(2, 8, 8, 1'b0, 1'b0, first);
        checks += 2;
        if (beat_q.size() != 0) begin errors++; $display("FAIL rstfull_idle_beats: got %0d want 0", beat_q.size()); end
        if (locked !== 1'b0) begin errors++; $display("FAIL rstfull_idle: got %b want 0", locked); end
        vsync_pulse();
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL rstfull_relock: got %b want 1", locked); end
    endtask

    task automatic test_clr_overflow();
        m_axis_tready = 1'b0;
        // With an empty FIFO, pixel 32 is the first refused; it reaches the write stage while
        // pixel 33 is on the input, so the clear is timed to collide with that drop.
        for (int p = 0; p < 40; p++) begin
            vid_active_video = 1'b1;
            vid_data = DW'($urandom);
            clr_overflow = (p == 33);
            if (p == 33) begin
                checks++;
                if (overflow !== 1'b0) begin errors++; $display("FAIL clr_pre_drop: got %b want 0", overflow); end
            end
            tick();
        end
        vid_active_video = 1'b0;
        clr_overflow = 1'b0;
        tick();
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL clr_collide: got %b want 1", overflow); end
        if (locked !== 1'b0) begin errors++; $display("FAIL clr_dropped: got %b want 0", locked); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b want 0", overflow); end
        m_axis_tready = 1'b1;
        repeat (40) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_timing();
        test_reset_midframe();
        test_overflow();
        test_swap();
        test_reset_full();
        test_clr_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
